// File: rtl/score_table.sv
// High-score table: per-player personal best plus overall leader, one submission in flight.
// Optional SCORE_QUERY_EN macro builds a registered read-back port on the best-score array.
module score_table #(
    parameter int unsigned NUM_PLAYERS = 5,
    parameter int unsigned SCORE_W     = 7,
    parameter int unsigned ID_W        = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               enable,
    input  logic [ID_W-1:0]    Player_ID,
    input  logic [SCORE_W-1:0] Current_Score,
    output logic               Ready,
    output logic               Done,
    output logic [SCORE_W-1:0] Personel_Best,
    output logic [SCORE_W-1:0] Highest_Score,
    output logic [ID_W-1:0]    Player_Won,
    output logic               New_Personal,
    output logic               New_High,
    output logic               Id_Error,
    input  logic [ID_W-1:0]    Query_ID,
    output logic [SCORE_W-1:0] Query_Score
);

    localparam logic [ID_W:0] LP_NUM = NUM_PLAYERS[ID_W:0];

    typedef enum logic [1:0] {StIdle, StCompare, StCommit} state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [SCORE_W-1:0] r_best [NUM_PLAYERS];
    logic [SCORE_W-1:0] r_lead_score;
    logic [ID_W-1:0]    r_lead_id;

    logic [ID_W-1:0]    r_id;
    logic [SCORE_W-1:0] r_score;
    logic               r_valid;
    logic [SCORE_W-1:0] r_stored;
    logic               r_gt_best;
    logic               r_gt_lead;

    logic               r_done;
    logic [SCORE_W-1:0] r_pb;
    logic               r_new_personal;
    logic               r_new_high;
    logic               r_id_error;

    logic               w_id_valid;
    logic [SCORE_W-1:0] w_stored;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (enable) w_state_next = StCompare;
            StCompare: w_state_next = StCommit;
            StCommit:  w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    // Out-of-range IDs never index the array.
    assign w_id_valid = ({1'b0, r_id} < LP_NUM);
    assign w_stored   = w_id_valid ? r_best[r_id] : '0;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_id      <= '0;
            r_score   <= '0;
            r_valid   <= 1'b0;
            r_stored  <= '0;
            r_gt_best <= 1'b0;
            r_gt_lead <= 1'b0;
        end else begin
            if (r_state == StIdle && enable) begin
                r_id    <= Player_ID;
                r_score <= Current_Score;
            end
            if (r_state == StCompare) begin
                r_valid   <= w_id_valid;
                r_stored  <= w_stored;
                r_gt_best <= (r_score > w_stored);
                r_gt_lead <= (r_score > r_lead_score);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < int'(NUM_PLAYERS); i++) r_best[i] <= '0;
            r_lead_score   <= '0;
            r_lead_id      <= '0;
            r_done         <= 1'b0;
            r_pb           <= '0;
            r_new_personal <= 1'b0;
            r_new_high     <= 1'b0;
            r_id_error     <= 1'b0;
        end else begin
            r_done <= (r_state == StCommit);
            if (r_state == StCommit) begin
                r_new_personal <= 1'b0;
                r_new_high     <= 1'b0;
                r_id_error     <= !r_valid;
                if (!r_valid) begin
                    r_pb <= '0;
                end else if (r_gt_best) begin
                    r_best[r_id]   <= r_score;
                    r_pb           <= r_score;
                    r_new_personal <= 1'b1;
                    // Strict compare: ties leave the earlier leader in place.
                    if (r_gt_lead) begin
                        r_lead_score <= r_score;
                        r_lead_id    <= r_id;
                        r_new_high   <= 1'b1;
                    end
                end else begin
                    r_pb <= r_stored;
                end
            end
        end
    end

    assign Ready         = (r_state == StIdle);
    assign Done          = r_done;
    assign Personel_Best = r_pb;
    assign New_Personal  = r_new_personal;
    assign New_High      = r_new_high;
    assign Id_Error      = r_id_error;

    // Leader registers only change in COMMIT, so they double as the held outputs.
    assign Highest_Score = r_lead_score;
    assign Player_Won    = r_lead_id;

`ifdef SCORE_QUERY_EN
    logic [SCORE_W-1:0] r_query;
    logic               w_query_valid;

    assign w_query_valid = ({1'b0, Query_ID} < LP_NUM);

    always_ff @(posedge Clk) begin
        if (!Reset)             r_query <= '0;
        else if (w_query_valid) r_query <= r_best[Query_ID];
        else                    r_query <= '0;
    end

    assign Query_Score = r_query;
`else
    logic w_unused_query;
    assign w_unused_query = ^Query_ID;
    assign Query_Score    = '0;
`endif

endmodule

// File: tb/tb_score_table.sv
// Scoreboard bench for score_table: expected results queued at accept, compared on Done.
module tb_score_table;

    localparam int unsigned NP = 5;
    localparam int unsigned SW = 7;
    localparam int unsigned IW = 3;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          enable;
    logic [IW-1:0] Player_ID;
    logic [SW-1:0] Current_Score;
    logic          Ready;
    logic          Done;
    logic [SW-1:0] Personel_Best;
    logic [SW-1:0] Highest_Score;
    logic [IW-1:0] Player_Won;
    logic          New_Personal;
    logic          New_High;
    logic          Id_Error;
    logic [IW-1:0] Query_ID;
    logic [SW-1:0] Query_Score;

    score_table #(.NUM_PLAYERS(NP), .SCORE_W(SW), .ID_W(IW)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .enable        (enable),
        .Player_ID     (Player_ID),
        .Current_Score (Current_Score),
        .Ready         (Ready),
        .Done          (Done),
        .Personel_Best (Personel_Best),
        .Highest_Score (Highest_Score),
        .Player_Won    (Player_Won),
        .New_Personal  (New_Personal),
        .New_High      (New_High),
        .Id_Error      (Id_Error),
        .Query_ID      (Query_ID),
        .Query_Score   (Query_Score)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned pb;
        int unsigned hs;
        int unsigned pw;
        int unsigned np;
        int unsigned nh;
        int unsigned ie;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned m_best [NP];
    int unsigned m_lead_score;
    int unsigned m_lead_id;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NP); i++) m_best[i] = 0;
        m_lead_score = 0;
        m_lead_id    = 0;
    endtask

    function automatic exp_t model_submit(input int unsigned id, input int unsigned score);
        exp_t e;
        e.np = 0;
        e.nh = 0;
        e.ie = 0;
        if (id >= NP) begin
            e.ie = 1;
            e.pb = 0;
        end else if (score > m_best[id]) begin
            m_best[id] = score;
            e.np = 1;
            e.pb = score;
            if (score > m_lead_score) begin
                m_lead_score = score;
                m_lead_id    = id;
                e.nh = 1;
            end
        end else begin
            e.pb = m_best[id];
        end
        e.hs = m_lead_score;
        e.pw = m_lead_id;
        return e;
    endfunction

    always @(negedge Clk) begin
        if (Done) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 32'(Done), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("personel_best", 32'(Personel_Best), e.pb);
                check_val("highest_score", 32'(Highest_Score), e.hs);
                check_val("player_won",    32'(Player_Won),    e.pw);
                check_val("new_personal",  32'(New_Personal),  e.np);
                check_val("new_high",      32'(New_High),      e.nh);
                check_val("id_error",      32'(Id_Error),      e.ie);
            end
        end
    end

    // Returns at the negedge where Done should be high; junk enables while busy must be dropped.
    task automatic submit(input int unsigned id, input int unsigned score);
        @(negedge Clk);
        check_val("ready_before", 32'(Ready), 1);
        enable        = 1'b1;
        Player_ID     = IW'(id);
        Current_Score = SW'(score);
        sb_q.push_back(model_submit(id, score));
        @(negedge Clk);
        check_val("ready_compare", 32'(Ready), 0);
        Player_ID     = ~IW'(id);
        Current_Score = ~SW'(score);
        @(negedge Clk);
        check_val("done_early", 32'(Done), 0);
        enable = 1'b0;
        @(negedge Clk);
        check_val("done_latency", 32'(Done), 1);
        check_val("ready_after",  32'(Ready), 1);
    endtask

    initial begin
        Reset         = 1'b0;
        enable        = 1'b0;
        Player_ID     = '0;
        Current_Score = '0;
        Query_ID      = 3'd2;
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        check_val("rst_ready", 32'(Ready), 1);
        check_val("rst_done",  32'(Done), 0);
        check_val("rst_pb",    32'(Personel_Best), 0);
        check_val("rst_hs",    32'(Highest_Score), 0);
        check_val("rst_pw",    32'(Player_Won), 0);
        check_val("rst_flags", 32'({New_Personal, New_High, Id_Error}), 0);
        check_val("rst_query", 32'(Query_Score), 0);

        submit(0, 25);
        submit(2, 25);
        submit(2, 40);
        submit(2, 30);
        submit(6, 99);
        check_val("hold_hs", 32'(Highest_Score), 40);
        submit(7, 0);
        submit(4, 127);
        submit(4, 127);
        submit(1, 10);

        // Query of an entry written at the same edge returns the old value first.
        submit(2, 60);
`ifdef SCORE_QUERY_EN
        check_val("query_old", 32'(Query_Score), 40);
        @(negedge Clk);
        check_val("query_new", 32'(Query_Score), 60);
        Query_ID = 3'd6;
        @(negedge Clk);
        @(negedge Clk);
        check_val("query_oob", 32'(Query_Score), 0);
`else
        check_val("query_off", 32'(Query_Score), 0);
        @(negedge Clk);
        check_val("query_off2", 32'(Query_Score), 0);
`endif

        // Reset while the submission sits in COMPARE: no Done, table cleared.
        Query_ID = 3'd1;
        @(negedge Clk);
        enable        = 1'b1;
        Player_ID     = 3'd1;
        Current_Score = 7'd50;
        @(negedge Clk);
        enable = 1'b0;
        Reset  = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check_val("rst_nodone", 32'(Done), 0);
            @(negedge Clk);
        end
        check_val("mrst_ready", 32'(Ready), 1);
        check_val("mrst_pb",    32'(Personel_Best), 0);
        check_val("mrst_hs",    32'(Highest_Score), 0);
        check_val("mrst_pw",    32'(Player_Won), 0);
        check_val("mrst_flags", 32'({New_Personal, New_High, Id_Error}), 0);
        check_val("mrst_query", 32'(Query_Score), 0);

        submit(3, 5);
        submit(1, 3);

        @(negedge Clk);
        check_val("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1);
    end

endmodule
